// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream side (from spi_fast_core) and register-bus side of spi_reg_ctrl.
// The master modport is the controller; the slave modport is the core plus the register file.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        user_out;
    logic              user_out_stb;
    logic [7:0]        user_in;
    logic              user_in_ack;
    logic              csn_state;
    logic              csn_rise;
    logic              csn_fall;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [7:0]        bus_rdata;

    modport master (
        input  user_out, user_out_stb, user_in_ack, csn_state, csn_rise, csn_fall, bus_rdata,
        output user_in, bus_addr, bus_wdata, bus_we, bus_re
    );

    modport slave (
        output user_out, user_out_stb, user_in_ack, csn_state, csn_rise, csn_fall, bus_rdata,
        input  user_in, bus_addr, bus_wdata, bus_we, bus_re
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Turns chip-select framed SPI bytes into register-bus accesses: the first byte is a
// command (bit7 = read, low bits = start address), the following bytes are an auto-incrementing burst.
module spi_reg_ctrl #(
    parameter int         ADDR_W = 7,
    parameter logic [7:0] STATUS = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_reg_ctrl_if.master       bif,
    output logic                 busy,
    output logic                 rd_late
);
    typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD_WAIT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              fetch_phase, fetch_phase_n;
    logic [7:0]        user_in_n;
    logic [ADDR_W-1:0] bus_addr_n;
    logic [7:0]        bus_wdata_n;
    logic              bus_we_n, bus_re_n, busy_n, rd_late_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            fetch_phase  <= 1'b0;
            bif.user_in  <= 8'h00;
            bif.bus_addr <= '0;
            bif.bus_wdata <= 8'h00;
            bif.bus_we   <= 1'b0;
            bif.bus_re   <= 1'b0;
            busy         <= 1'b0;
            rd_late      <= 1'b0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            fetch_phase  <= fetch_phase_n;
            bif.user_in  <= user_in_n;
            bif.bus_addr <= bus_addr_n;
            bif.bus_wdata <= bus_wdata_n;
            bif.bus_we   <= bus_we_n;
            bif.bus_re   <= bus_re_n;
            busy         <= busy_n;
            rd_late      <= rd_late_n;
        end
    end

    // A fetch spends two cycles in RD_FETCH: phase 0 drives bus_re, phase 1 captures bus_rdata.
    always_comb begin
        state_n       = state;
        addr_n        = addr;
        fetch_phase_n = fetch_phase;
        user_in_n     = bif.user_in;
        bus_addr_n    = bif.bus_addr;
        bus_wdata_n   = bif.bus_wdata;
        bus_we_n      = 1'b0;
        bus_re_n      = 1'b0;
        rd_late_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bif.csn_fall) begin
                    state_n   = CMD;
                    user_in_n = STATUS;
                end
            end
            CMD: begin
                if (bif.user_out_stb) begin
                    addr_n = bif.user_out[ADDR_W-1:0];
                    if (bif.user_out[7]) begin
                        state_n       = RD_FETCH;
                        bus_re_n      = 1'b1;
                        bus_addr_n    = bif.user_out[ADDR_W-1:0];
                        fetch_phase_n = 1'b0;
                    end else begin
                        state_n = WR;
                    end
                end
            end
            WR: begin
                if (bif.user_out_stb) begin
                    bus_we_n    = 1'b1;
                    bus_addr_n  = addr;
                    bus_wdata_n = bif.user_out;
                    addr_n      = addr + ADDR_W'(1);
                end
            end
            RD_FETCH: begin
                rd_late_n = bif.user_in_ack;
                if (!fetch_phase) begin
                    fetch_phase_n = 1'b1;
                end else begin
                    user_in_n = bif.bus_rdata;
                    addr_n    = addr + ADDR_W'(1);
                    state_n   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bif.user_in_ack) begin
                    state_n       = RD_FETCH;
                    bus_re_n      = 1'b1;
                    bus_addr_n    = addr;
                    fetch_phase_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Frame boundaries override the byte handling, except that a write already
        // strobed in alongside the boundary is still issued.
        if (state != IDLE) begin
            if (bif.csn_fall || bif.csn_rise || bif.csn_state) begin
                if (bus_re_n) begin
                    bus_addr_n = bif.bus_addr;
                end
                bus_re_n      = 1'b0;
                fetch_phase_n = 1'b0;
                if (bif.csn_fall) begin
                    state_n   = CMD;
                    user_in_n = STATUS;
                end else begin
                    state_n   = IDLE;
                    user_in_n = bif.user_in;
                end
            end
        end

        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write/read bursts, address wrap, abort, late ack and reset.
module tb_spi_reg_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy, rd_late;
    int   total = 0;
    int   bad = 0;
    int   re_count = 0;

    spi_reg_ctrl_if #(.ADDR_W(7)) bif ();

    spi_reg_ctrl #(.ADDR_W(7), .STATUS(8'hA5)) dut (
        .clk     (clk),
        .rst     (rst),
        .bif     (bif),
        .busy    (busy),
        .rd_late (rd_late)
    );

    always #5 clk = ~clk;

    // Registered register-file model: data appears the cycle after bus_re.
    always @(posedge clk) begin
        if (bif.bus_re) bif.bus_rdata <= {1'b0, bif.bus_addr} ^ 8'hFF;
    end

    always @(negedge clk) begin
        if (bif.bus_re) re_count++;
        if (!rst) begin
            total++;
            if (bif.bus_we && bif.bus_re) begin
                bad++;
                $display("[TB] FAIL we_re_exclusive got=%b%b want=not both", bif.bus_we, bif.bus_re);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        bif.csn_fall  = 1'b1;
        bif.csn_state = 1'b0;
        step();
        bif.csn_fall  = 1'b0;
    endtask

    task automatic frame_end();
        bif.csn_rise  = 1'b1;
        bif.csn_state = 1'b1;
        step();
        bif.csn_rise  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.user_out     = b;
        bif.user_out_stb = 1'b1;
        step();
        bif.user_out_stb = 1'b0;
    endtask

    task automatic pulse_ack();
        bif.user_in_ack = 1'b1;
        step();
        bif.user_in_ack = 1'b0;
    endtask

    task automatic test_reset();
        bif.user_out = 8'h00; bif.user_out_stb = 1'b0; bif.user_in_ack = 1'b0;
        bif.csn_state = 1'b1; bif.csn_rise = 1'b0; bif.csn_fall = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (bif.user_in !== 8'h00) begin bad++; $display("[TB] FAIL reset_user_in got=%h want=00", bif.user_in); end
        total++; if (bif.bus_addr !== 7'h00) begin bad++; $display("[TB] FAIL reset_bus_addr got=%h want=00", bif.bus_addr); end
        total++; if (bif.bus_wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_bus_wdata got=%h want=00", bif.bus_wdata); end
        total++; if ({bif.bus_we, bif.bus_re, busy, rd_late} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {bif.bus_we, bif.bus_re, busy, rd_late}); end
        step(); step();
        rst = 1'b0;
        step();
        // Strobes in IDLE do nothing.
        send_byte(8'h12);
        pulse_ack();
        total++; if ({bif.bus_we, bif.bus_re, busy} !== 3'b000) begin bad++; $display("[TB] FAIL idle_ignores got=%b want=000", {bif.bus_we, bif.bus_re, busy}); end
    endtask

    task automatic test_write_burst();
        logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
        frame_start();
        total++; if (bif.user_in !== 8'hA5) begin bad++; $display("[TB] FAIL wr_status got=%h want=a5", bif.user_in); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy got=%b want=1", busy); end
        send_byte(8'h10);
        total++; if (bif.bus_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_cmd_no_we got=%b want=0", bif.bus_we); end
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i]);
            total++; if (bif.bus_we !== 1'b1) begin bad++; $display("[TB] FAIL wr_we[%0d] got=%b want=1", i, bif.bus_we); end
            total++; if (bif.bus_addr !== 7'(8'h10 + i)) begin bad++; $display("[TB] FAIL wr_addr[%0d] got=%h want=%h", i, bif.bus_addr, 7'(8'h10 + i)); end
            total++; if (bif.bus_wdata !== data[i]) begin bad++; $display("[TB] FAIL wr_data[%0d] got=%h want=%h", i, bif.bus_wdata, data[i]); end
            step();
            total++; if (bif.bus_we !== 1'b0) begin bad++; $display("[TB] FAIL wr_we_width[%0d] got=%b want=0", i, bif.bus_we); end
        end
        total++; if (bif.user_in !== 8'hA5) begin bad++; $display("[TB] FAIL wr_user_in_hold got=%h want=a5", bif.user_in); end
        frame_end();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_end_busy got=%b want=0", busy); end
        step();
    endtask

    task automatic test_read_burst();
        int re0;
        logic [7:0] exp_data [3] = '{8'hFA, 8'hF9, 8'hF8};
        frame_start();
        re0 = re_count;
        send_byte(8'h85);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                step(); step();
                pulse_ack();
            end
            total++; if (bif.bus_re !== 1'b1 || bif.bus_addr !== 7'(5 + i)) begin bad++; $display("[TB] FAIL rd_re[%0d] got=%b/%h want=1/%h", i, bif.bus_re, bif.bus_addr, 7'(5 + i)); end
            step();
            total++; if (bif.bus_re !== 1'b0) begin bad++; $display("[TB] FAIL rd_re_width[%0d] got=%b want=0", i, bif.bus_re); end
            // user_in is written on the second clock after the triggering edge.
            step();
            total++; if (bif.user_in !== exp_data[i]) begin bad++; $display("[TB] FAIL rd_data[%0d] got=%h want=%h", i, bif.user_in, exp_data[i]); end
        end
        send_byte(8'h00);
        step(); step();
        total++; if (re_count - re0 !== 3) begin bad++; $display("[TB] FAIL rd_re_count got=%0d want=3", re_count - re0); end
        total++; if (bif.bus_we !== 1'b0) begin bad++; $display("[TB] FAIL rd_no_we got=%b want=0", bif.bus_we); end
        frame_end();
        step();
    endtask

    task automatic test_wrap();
        frame_start();
        send_byte(8'h7F);
        send_byte(8'hAA);
        total++; if (bif.bus_we !== 1'b1 || bif.bus_addr !== 7'h7F || bif.bus_wdata !== 8'hAA) begin bad++; $display("[TB] FAIL wrap_first got=%b/%h/%h want=1/7f/aa", bif.bus_we, bif.bus_addr, bif.bus_wdata); end
        send_byte(8'hBB);
        total++; if (bif.bus_we !== 1'b1 || bif.bus_addr !== 7'h00 || bif.bus_wdata !== 8'hBB) begin bad++; $display("[TB] FAIL wrap_second got=%b/%h/%h want=1/00/bb", bif.bus_we, bif.bus_addr, bif.bus_wdata); end
        frame_end();
        step();
    endtask

    task automatic test_abort();
        frame_start();
        send_byte(8'h20);
        send_byte(8'h44);
        bif.user_out     = 8'h55;
        bif.user_out_stb = 1'b1;
        bif.csn_rise     = 1'b1;
        bif.csn_state    = 1'b1;
        step();
        bif.user_out_stb = 1'b0;
        bif.csn_rise     = 1'b0;
        total++; if (bif.bus_we !== 1'b1 || bif.bus_addr !== 7'h21 || bif.bus_wdata !== 8'h55) begin bad++; $display("[TB] FAIL abort_write got=%b/%h/%h want=1/21/55", bif.bus_we, bif.bus_addr, bif.bus_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
        send_byte(8'h66);
        total++; if (bif.bus_we !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle_we got=%b want=0", bif.bus_we); end
        frame_start();
        total++; if (bif.user_in !== 8'hA5 || busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_restart got=%h/%b want=a5/1", bif.user_in, busy); end
        frame_end();
        step();
    endtask

    task automatic test_late_ack();
        int re0;
        frame_start();
        send_byte(8'h83);
        step(); step();
        total++; if (bif.user_in !== 8'hFC) begin bad++; $display("[TB] FAIL late_first got=%h want=fc", bif.user_in); end
        re0 = re_count;
        pulse_ack();
        pulse_ack();
        total++; if (rd_late !== 1'b1) begin bad++; $display("[TB] FAIL late_pulse got=%b want=1", rd_late); end
        step();
        total++; if (rd_late !== 1'b0) begin bad++; $display("[TB] FAIL late_width got=%b want=0", rd_late); end
        total++; if (bif.user_in !== 8'hFB) begin bad++; $display("[TB] FAIL late_fetch got=%h want=fb", bif.user_in); end
        step(); step(); step();
        total++; if (re_count - re0 !== 1) begin bad++; $display("[TB] FAIL late_re_count got=%0d want=1", re_count - re0); end
        frame_end();
        step();
    endtask

    task automatic test_reset_mid_frame();
        int re0;
        frame_start();
        send_byte(8'h81);
        total++; if (bif.bus_re !== 1'b1) begin bad++; $display("[TB] FAIL mid_re_before got=%b want=1", bif.bus_re); end
        #2 rst = 1'b1;
        bif.csn_state = 1'b1;
        #1;
        total++; if ({bif.bus_re, bif.bus_we, busy, rd_late} !== 4'b0000 || bif.user_in !== 8'h00 || bif.bus_addr !== 7'h00) begin bad++; $display("[TB] FAIL mid_async got=%b/%h/%h want=0000/00/00", {bif.bus_re, bif.bus_we, busy, rd_late}, bif.user_in, bif.bus_addr); end
        re0 = re_count;
        step();
        rst = 1'b0;
        step(); step(); step(); step();
        total++; if (re_count !== re0 || busy !== 1'b0 || bif.user_in !== 8'h00) begin bad++; $display("[TB] FAIL mid_after got=%0d/%b/%h want=%0d/0/00", re_count, busy, bif.user_in, re0); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_late_ack();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
